ghostbus_host_arb: RTL and testbench
====================================

// Module: ghostbus_host_arb
// PURPOSE
//  Multi-host arbiter and sequencer for the ghostbus: lets NREQ bus masters
//  (e.g. UART/Ethernet bridge, local init sequencer) share one gb_* host
//  port into a top like `top`. Runs one transaction at a time.
//  Drives a one-cycle write/read strobe, waits the fixed read latency,
//  captures gb_rdata, and returns a one-cycle ack to the granted requester.
// PARAMETERS
//  NREQ    2   number of requesters (2..8)
//  AW      24  ghostbus address width
//  DW      32  ghostbus data width
//  RD_LAT  1   cycles from gb_rstb cycle to gb_rdata valid (1..15)
// PORTS
//  gb_clk     in   1         bus clock; all logic on rising edge
//  gb_rst     in   1         asynchronous, active-high reset
//  req_valid  in   NREQ      request i pending; hold until ack[i]
//  req_we     in   NREQ      1=write, 0=read
//  req_addr   in   NREQ*AW   request i address, slice [(i+1)*AW-1 -: AW]
//  req_wdata  in   NREQ*DW   request i write data, same slicing
//  ack        out  NREQ      one-cycle completion pulse, one-hot or 0
//  rdata      out  DW        last captured read data; valid with ack on reads
//  busy       out  1         high in every state except IDLE
//  gb_addr    out  AW        bus address
//  gb_wdata   out  DW        bus write data
//  gb_wen     out  1         write enable (0 = read cycle)
//  gb_wstb    out  1         write strobe
//  gb_rstb    out  1         read strobe
//  gb_rdata   in   DW        bus read data
// BEHAVIOUR
//  - All outputs registered. Reset value of every output is 0.
//  - FSM states: IDLE, ISSUE, WAIT, ACK.
//  - IDLE: if any req_valid, pick winner; latch index, we, addr, wdata.
//    Go to ISSUE. Otherwise stay.
//  - ISSUE (1 cycle): gb_addr/gb_wdata = latched values.
//    Write: gb_wen=gb_wstb=1, next state ACK.
//    Read: gb_wen=0, gb_rstb=1, load cnt=RD_LAT, next state WAIT.
//  - WAIT: strobes 0; gb_addr held; cnt decrements each cycle.
//    At the edge where cnt reaches 0, capture rdata<=gb_rdata, go to ACK.
//  - ACK (1 cycle): ack[winner]=1. Next state IDLE; gb_addr returns to 0.
//  - Timing (request seen in IDLE at cycle T0):
//    Strobe is high in T1 only.
//    Write: ack in T2.
//    Read: gb_rdata sampled at end of T1+RD_LAT; ack in T2+RD_LAT.
//    Minimum issue spacing: 3 cycles (write) or 3+RD_LAT cycles (read).
//  - Round-robin: last-grant pointer; search starts at last+1 mod NREQ.
//    Pointer resets to NREQ-1, so requester 0 wins first.
//    Pointer updates only on grant.
//  - Dropping req_valid before grant = withdrawn, never acked.
//    Once latched, the transaction completes and acks even if req_valid drops.
//  - req_valid[i] still high in the cycle after ack[i]: new request,
//    arbitrated normally.
//  - rdata unchanged by writes; holds until the next read capture.
//  - Reset mid-operation: all outputs 0 immediately (async); FSM to IDLE;
//    pointer reset; in-flight transaction dropped, no ack.
// CONFIGURATION
//  GHOSTBUS_ARB_PRIORITY_EN
//    defined: fixed priority, lowest requester index always wins.
//             No pointer; lower indices may starve higher ones.
//    undefined (default): round-robin as above.
// TESTING
//  1. RD_LAT=1, req0 write addr 0x000000 data 0x42 at T0
//     -> T1 gb_wen=gb_wstb=1, gb_addr=0, gb_wdata=0x42;
//        ack=2'b01 in T2; rdata stays 0.
//  2. req1 read addr 0x000001; bench drives gb_rdata=0x0000000e in T2
//     -> gb_rstb=1 only in T1, gb_wen=0;
//        ack=2'b10 in T3; rdata=0x0000000e.
//  3. req0 and req1 held high, 4 writes
//     -> grant order 0,1,0,1.
//     With GHOSTBUS_ARB_PRIORITY_EN -> order 0,0,0,0.
//  4. gb_rst pulsed during WAIT of a read
//     -> all outputs 0 in same cycle; no ack;
//        after release with both requesting, req0 granted first.
//  5. req1 high for one cycle only, while FSM is in ISSUE for req0
//     -> req1 never acked; busy=0 after req0's ack.
//  6. RD_LAT=3 read at T0 -> gb_rdata sampled end of T4; ack in T5.

Source files
------------

// File: rtl/ghostbus_host_arb.sv
// ghostbus_host_arb: lets NREQ bus masters share one ghostbus host port.
// The arbiter runs one transaction at a time. It issues a one-cycle write or read
// strobe, waits RD_LAT cycles on reads, then returns a one-cycle ack to the winner.
// Optional macro GHOSTBUS_ARB_PRIORITY_EN selects fixed priority, where the lowest
// index always wins. When the macro is undefined, arbitration is round-robin.
// All outputs are registered and reset asynchronously to zero.
module ghostbus_host_arb #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned AW     = 24,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic               gb_clk,
  input  logic               gb_rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic [AW-1:0]      gb_addr,
  output logic [DW-1:0]      gb_wdata,
  output logic               gb_wen,
  output logic               gb_wstb,
  output logic               gb_rstb,
  input  logic [DW-1:0]      gb_rdata
);

  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]  LAT = 4'(RD_LAT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e          r_state, w_state_d;
  logic [IW-1:0]   r_idx, w_idx_d;
  logic            r_we, w_we_d;
  logic [3:0]      r_cnt, w_cnt_d;
  logic [NREQ-1:0] w_ack_d;
  logic [DW-1:0]   w_rdata_d;
  logic            w_busy_d;
  logic [AW-1:0]   w_addr_d;
  logic [DW-1:0]   w_wdata_d;
  logic            w_wen_d;
  logic            w_wstb_d;
  logic            w_rstb_d;
  logic            w_any;
  logic [IW-1:0]   w_win;

  logic [AW-1:0]   w_addr_arr  [NREQ];
  logic [DW-1:0]   w_wdata_arr [NREQ];

`ifndef GHOSTBUS_ARB_PRIORITY_EN
  logic [IW-1:0]   r_last, w_last_d;
  logic            w_found;
  int unsigned     w_cand;
`endif

  // Unpack the flat request buses so the winner index can select a slice directly.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr_arr[g]  = req_addr[g*AW +: AW];
    assign w_wdata_arr[g] = req_wdata[g*DW +: DW];
  end

  assign w_any = |req_valid;

`ifdef GHOSTBUS_ARB_PRIORITY_EN
  // Fixed priority: scan downward so that the lowest asserted index is the last one written.
  always_comb begin
    w_win = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_valid[IW'(i)]) begin
        w_win = IW'(i);
      end
    end
  end
`else
  // Round-robin: pick the first asserted requester after the last grant, wrapping at NREQ.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = 32'(r_last) + k;
      if (w_cand >= NREQ) begin
        w_cand = w_cand - NREQ;
      end
      if (!w_found && req_valid[IW'(w_cand)]) begin
        w_found = 1'b1;
        w_win   = IW'(w_cand);
      end
    end
  end
`endif

  // Next-state logic. Every output is computed one cycle ahead, so the register holds it
  // in the same cycle as the matching state.
  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_we_d    = r_we;
    w_cnt_d   = r_cnt;
    w_ack_d   = '0;
    w_rdata_d = rdata;
    w_addr_d  = gb_addr;
    w_wdata_d = gb_wdata;
    w_wen_d   = 1'b0;
    w_wstb_d  = 1'b0;
    w_rstb_d  = 1'b0;
`ifndef GHOSTBUS_ARB_PRIORITY_EN
    w_last_d  = r_last;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          w_state_d = StIssue;
          w_idx_d   = w_win;
          w_we_d    = req_we[w_win];
          w_addr_d  = w_addr_arr[w_win];
          w_wdata_d = w_wdata_arr[w_win];
          w_wen_d   = req_we[w_win];
          w_wstb_d  = req_we[w_win];
          w_rstb_d  = ~req_we[w_win];
`ifndef GHOSTBUS_ARB_PRIORITY_EN
          w_last_d  = w_win;
`endif
        end
      end
      StIssue: begin
        if (r_we) begin
          w_state_d = StAck;
        end else begin
          w_state_d = StWait;
          w_cnt_d   = LAT;
        end
      end
      StWait: begin
        w_cnt_d = r_cnt - 4'd1;
        // This edge takes the counter to zero. gb_rdata is valid here, so capture it now.
        if (r_cnt == 4'd1) begin
          w_state_d = StAck;
          w_rdata_d = gb_rdata;
        end
      end
      StAck: begin
        w_state_d = StIdle;
        w_addr_d  = '0;
        w_wdata_d = '0;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
    if (w_state_d == StAck) begin
      w_ack_d[r_idx] = 1'b1;
    end
    w_busy_d = (w_state_d != StIdle);
  end

  // FSM state register.
  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Latched transaction, read-latency counter and registered outputs.
  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      r_idx    <= '0;
      r_we     <= 1'b0;
      r_cnt    <= '0;
      ack      <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      gb_addr  <= '0;
      gb_wdata <= '0;
      gb_wen   <= 1'b0;
      gb_wstb  <= 1'b0;
      gb_rstb  <= 1'b0;
    end else begin
      r_idx    <= w_idx_d;
      r_we     <= w_we_d;
      r_cnt    <= w_cnt_d;
      ack      <= w_ack_d;
      rdata    <= w_rdata_d;
      busy     <= w_busy_d;
      gb_addr  <= w_addr_d;
      gb_wdata <= w_wdata_d;
      gb_wen   <= w_wen_d;
      gb_wstb  <= w_wstb_d;
      gb_rstb  <= w_rstb_d;
    end
  end

`ifndef GHOSTBUS_ARB_PRIORITY_EN
  // Round-robin pointer. It resets to NREQ-1 so that requester 0 wins the first grant.
  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      r_last <= IW'(NREQ - 1);
    end else begin
      r_last <= w_last_d;
    end
  end
`endif

endmodule

// File: tb/tb_ghostbus_host_arb.sv
// Bench for ghostbus_host_arb.
// It runs directed scenarios, then a randomized phase.
// The randomized phase is checked against a transaction-timing model.
module tb_ghostbus_host_arb;
  localparam int NREQ = 2;
  localparam int AW   = 24;
  localparam int DW   = 32;
  localparam int LAT  = 1;
  localparam int NRND = 400;

  logic gb_clk = 1'b0;
  logic gb_rst = 1'b1;
  always #5 gb_clk = ~gb_clk;

  logic [NREQ-1:0]    req_valid, req_we, ack;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]      rdata, gb_wdata, gb_rdata;
  logic [AW-1:0]      gb_addr;
  logic               busy, gb_wen, gb_wstb, gb_rstb;

  logic [NREQ-1:0]    l3_req_valid, l3_req_we, l3_ack;
  logic [NREQ*AW-1:0] l3_req_addr;
  logic [NREQ*DW-1:0] l3_req_wdata;
  logic [DW-1:0]      l3_rdata, l3_gb_wdata, l3_gb_rdata;
  logic [AW-1:0]      l3_gb_addr;
  logic               l3_busy, l3_gb_wen, l3_gb_wstb, l3_gb_rstb;

  ghostbus_host_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(LAT)) u_dut (
    .gb_clk(gb_clk), .gb_rst(gb_rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .busy(busy),
    .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_wen(gb_wen), .gb_wstb(gb_wstb),
    .gb_rstb(gb_rstb), .gb_rdata(gb_rdata)
  );

  ghostbus_host_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(3)) u_dut3 (
    .gb_clk(gb_clk), .gb_rst(gb_rst), .req_valid(l3_req_valid), .req_we(l3_req_we),
    .req_addr(l3_req_addr), .req_wdata(l3_req_wdata), .ack(l3_ack), .rdata(l3_rdata),
    .busy(l3_busy), .gb_addr(l3_gb_addr), .gb_wdata(l3_gb_wdata), .gb_wen(l3_gb_wen),
    .gb_wstb(l3_gb_wstb), .gb_rstb(l3_gb_rstb), .gb_rdata(l3_gb_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge gb_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  // Reference arbitration rule. p is the last granted index and v is the pending set.
  function automatic int pick(input int p, input logic [NREQ-1:0] v);
`ifdef GHOSTBUS_ARB_PRIORITY_EN
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
`else
    for (int k = 1; k <= NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
    return 0;
  endfunction

  // Model storage for the randomized phase: expected outputs, kept in a ring indexed by cycle.
  logic [NREQ-1:0] e_ack   [16];
  logic            e_wstb  [16];
  logic            e_rstb  [16];
  logic            e_busy  [16];
  logic            e_cap   [16];
  logic [AW-1:0]   e_addr  [16];
  logic [DW-1:0]   e_wdata [16];
  int              rq_st   [NREQ];  // 0 free, 1 pending, 2 granted and awaiting ack

  initial begin
    logic [NREQ-1:0] g [4];
    int              t [4];
    int              n, s, w, dur, ptr, arb_at;
    logic [DW-1:0]   m_rdata;
    logic [NREQ-1:0] onehot;

    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; gb_rdata = '0;
    l3_req_valid = '0; l3_req_we = '0; l3_req_addr = '0; l3_req_wdata = '0; l3_gb_rdata = '0;

    // Reset values.
    nxt(); nxt();
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bus", {gb_addr, gb_wen, gb_wstb, gb_rstb}, 0);
    chk("rst_wdata", gb_wdata, 0);
    chk("rst_l3", {l3_ack, l3_busy, l3_gb_addr, l3_gb_rstb, l3_gb_wstb}, 0);
    gb_rst = 1'b0;
    nxt();
    chk("idle_busy", busy, 0);

    // Test 1: req0 writes 0x42 to address 0.
    set_req(0, 1'b1, 1'b1, 24'h0, 32'h42);
    nxt();
    chk("t1_strobes", {gb_wen, gb_wstb, gb_rstb}, 3'b110);
    chk("t1_addr", gb_addr, 0);
    chk("t1_wdata", gb_wdata, 32'h42);
    chk("t1_ack_T1", ack, 0);
    chk("t1_busy", busy, 1);
    nxt();
    chk("t1_ack_T2", ack, 2'b01);
    chk("t1_wstb_T2", gb_wstb, 0);
    chk("t1_rdata", rdata, 0);
    req_valid = '0;
    nxt();
    chk("t1_ack_T3", ack, 0);
    chk("t1_busy_T3", busy, 0);

    // Test 2: req1 reads address 1. The bench drives 0x0e on gb_rdata in T2 only.
    set_req(1, 1'b1, 1'b0, 24'h1, 32'h0);
    gb_rdata = 32'h33;
    nxt();
    chk("t2_strobes", {gb_wen, gb_wstb, gb_rstb}, 3'b001);
    chk("t2_addr_T1", gb_addr, 24'h1);
    gb_rdata = 32'h11;
    nxt();
    chk("t2_rstb_T2", gb_rstb, 0);
    chk("t2_ack_T2", ack, 0);
    chk("t2_addr_T2", gb_addr, 24'h1);
    gb_rdata = 32'h0000000e;
    nxt();
    chk("t2_ack_T3", ack, 2'b10);
    chk("t2_rdata", rdata, 32'h0000000e);
    gb_rdata = 32'h22;
    req_valid = '0;
    nxt();
    chk("t2_ack_T4", ack, 0);
    chk("t2_busy_T4", busy, 0);
    chk("t2_rdata_hold", rdata, 32'h0000000e);
    chk("t2_addr_idle", gb_addr, 0);

    // Test 3: both requesters hold back-to-back writes. Collect four grants.
    set_req(0, 1'b1, 1'b1, 24'h10, 32'hA0);
    set_req(1, 1'b1, 1'b1, 24'h11, 32'hB1);
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      nxt();
      if (ack != 0) begin
        g[n] = ack;
        t[n] = k;
        n++;
      end
    end
    req_valid = '0;
    chk("t3_nacks", n, 4);
    for (int j = 0; j < n; j++) begin
`ifdef GHOSTBUS_ARB_PRIORITY_EN
      chk($sformatf("t3_grant%0d", j), g[j], 2'b01);
`else
      chk($sformatf("t3_grant%0d", j), g[j], (j % 2 == 0) ? 2'b01 : 2'b10);
`endif
      if (j > 0) chk($sformatf("t3_gap%0d", j), t[j] - t[j-1], 3);
    end
    nxt();
    chk("t3_busy_end", busy, 0);

    // Test 4: reset during the WAIT of a req0 read. Afterwards req0 must win again.
    set_req(0, 1'b1, 1'b0, 24'h55, 32'h0);
    nxt();
    chk("t4_rstb", gb_rstb, 1);
    nxt();
    chk("t4_wait", {busy, gb_addr}, {1'b1, 24'h55});
    gb_rst = 1'b1;
    #1;
    chk("t4_async_ack", ack, 0);
    chk("t4_async_busy", busy, 0);
    chk("t4_async_bus", {gb_addr, gb_wen, gb_wstb, gb_rstb}, 0);
    chk("t4_async_data", {gb_wdata, rdata}, 0);
    set_req(0, 1'b1, 1'b1, 24'h60, 32'hC0);
    set_req(1, 1'b1, 1'b1, 24'h61, 32'hC1);
    nxt();
    chk("t4_in_rst", busy, 0);
    gb_rst = 1'b0;
    nxt();
    chk("t4_first_wdata", gb_wdata, 32'hC0);
    chk("t4_no_stale_ack", ack, 0);
    nxt();
    chk("t4_first_ack", ack, 2'b01);
    req_valid = '0;
    nxt();
    chk("t4_idle", {ack, busy}, 0);

    // Test 5: req1 pulses for one cycle while req0 is in ISSUE. req1 must never be acked.
    set_req(0, 1'b1, 1'b1, 24'h70, 32'hD0);
    nxt();
    set_req(1, 1'b1, 1'b1, 24'h71, 32'hD1);
    chk("t5_wstb", gb_wstb, 1);
    nxt();
    req_valid = '0;
    chk("t5_ack0", ack, 2'b01);
    for (int k = 0; k < 6; k++) begin
      nxt();
      chk($sformatf("t5_quiet%0d", k), {ack, busy}, 0);
    end

    // Test 6: RD_LAT=3 instance. gb_rdata is 0x100+k in cycle Tk.
    l3_req_valid[0] = 1'b1; l3_req_we[0] = 1'b0; l3_req_addr[AW-1:0] = 24'h5;
    l3_gb_rdata = 32'h100;
    for (int k = 1; k <= 7; k++) begin
      nxt();
      l3_gb_rdata = 32'h100 + 32'(k);
      chk($sformatf("t6_rstb%0d", k), l3_gb_rstb, (k == 1) ? 1'b1 : 1'b0);
      chk($sformatf("t6_ack%0d", k), l3_ack, (k == 5) ? 2'b01 : 2'b00);
      chk($sformatf("t6_busy%0d", k), l3_busy, (k <= 5) ? 1'b1 : 1'b0);
      chk($sformatf("t6_rdata%0d", k), l3_rdata, (k >= 5) ? 32'h104 : 32'h0);
      if (k == 5) l3_req_valid = '0;
    end

    // Randomized phase against the timing model.
    req_valid = '0;
    gb_rst = 1'b1;
    nxt();
    gb_rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      e_ack[i] = '0; e_wstb[i] = 0; e_rstb[i] = 0; e_busy[i] = 0; e_cap[i] = 0;
      e_addr[i] = '0; e_wdata[i] = '0;
    end
    for (int i = 0; i < NREQ; i++) rq_st[i] = 0;
    ptr = NREQ - 1; arb_at = 0; m_rdata = '0;
    for (int c = 0; c < NRND; c++) begin
      s = c % 16;
      chk("r_ack", ack, e_ack[s]);
      chk("r_wstb", gb_wstb, e_wstb[s]);
      chk("r_rstb", gb_rstb, e_rstb[s]);
      chk("r_busy", busy, e_busy[s]);
      chk("r_addr", gb_addr, e_addr[s]);
      chk("r_rdata", rdata, m_rdata);
      if (e_wstb[s]) begin
        chk("r_wdata", gb_wdata, e_wdata[s]);
        chk("r_wen_w", gb_wen, 1);
      end
      if (e_rstb[s]) chk("r_wen_r", gb_wen, 0);
      // Requesters react to completion, raise new work, withdraw, or drop after latching.
      for (int i = 0; i < NREQ; i++) begin
        if (e_ack[s][i]) rq_st[i] = 0;
        if (rq_st[i] == 0) begin
          if ($urandom_range(0, 2) == 0) begin
            rq_st[i] = 1;
            set_req(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
          end else begin
            req_valid[i] = 1'b0;
          end
        end else if (rq_st[i] == 1) begin
          if ($urandom_range(0, 15) == 0) begin
            req_valid[i] = 1'b0;
            rq_st[i] = 0;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      gb_rdata = $urandom;
      if (e_cap[s]) m_rdata = gb_rdata;
      e_ack[s] = '0; e_wstb[s] = 0; e_rstb[s] = 0; e_busy[s] = 0; e_cap[s] = 0;
      e_addr[s] = '0; e_wdata[s] = '0;
      if (c == arb_at) begin
        if (req_valid != 0) begin
          w = pick(ptr, req_valid);
          dur = req_we[w] ? 2 : 2 + LAT;
          for (int j = 1; j <= dur; j++) begin
            e_busy[(c + j) % 16] = 1'b1;
            e_addr[(c + j) % 16] = req_addr[w*AW +: AW];
          end
          onehot = '0;
          onehot[w] = 1'b1;
          e_ack[(c + dur) % 16] = onehot;
          if (req_we[w]) begin
            e_wstb[(c + 1) % 16]  = 1'b1;
            e_wdata[(c + 1) % 16] = req_wdata[w*DW +: DW];
          end else begin
            e_rstb[(c + 1) % 16]      = 1'b1;
            e_cap[(c + 1 + LAT) % 16] = 1'b1;
          end
          rq_st[w] = 2;
          ptr = w;
          arb_at = c + dur + 1;
        end else begin
          arb_at = c + 1;
        end
      end
      nxt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
